// File: rtl/hold_n.sv
// Two-phase hold sequencer: g for G_CYC cycles, then f for F_CYC cycles,
// one-shot or looped with optional idle gap, abort and completed-period count.
module hold_n #(
    parameter int G_CYC   = 2,
    parameter int F_CYC   = 2,
    parameter int GAP_CYC = 1,
    parameter int CNT_W   = 8,
    parameter int PCNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              loop,
    input  logic              abort,
    output logic              g,
    output logic              f,
    output logic              busy,
    output logic              done,
    output logic [PCNT_W-1:0] period_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G_PH = 2'd1,
        F_PH = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] G_LD   = CNT_W'(G_CYC - 1);
    localparam logic [CNT_W-1:0] F_LD   = CNT_W'(F_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                g_q;
    logic                f_q;
    logic                busy_q;
    logic                done_q;
    logic [PCNT_W-1:0]   period_cnt_q;
    logic [PCNT_W-1:0]   period_cnt_d;
    logic                cnt_zero;

    assign period_cnt_d = period_cnt_q + PCNT_W'(1);
    assign cnt_zero     = (cnt_q == '0);

    // Outputs are loaded alongside the state so they always reflect the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            g_q          <= 1'b0;
            f_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            period_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && abort) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                g_q     <= 1'b0;
                f_q     <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && !abort) begin
                            state_q      <= G_PH;
                            cnt_q        <= G_LD;
                            g_q          <= 1'b1;
                            busy_q       <= 1'b1;
                            period_cnt_q <= '0;
                        end
                    end
                    G_PH: begin
                        if (cnt_zero) begin
                            state_q <= F_PH;
                            cnt_q   <= F_LD;
                            g_q     <= 1'b0;
                            f_q     <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    F_PH: begin
                        if (cnt_zero) begin
                            period_cnt_q <= period_cnt_d;
                            f_q          <= 1'b0;
                            if (loop && GAP_CYC > 0) begin
                                state_q <= GAP;
                                cnt_q   <= GAP_LD;
                            end else if (loop) begin
                                state_q <= G_PH;
                                cnt_q   <= G_LD;
                                g_q     <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    GAP: begin
                        if (cnt_zero) begin
                            state_q <= G_PH;
                            cnt_q   <= G_LD;
                            g_q     <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        g_q     <= 1'b0;
                        f_q     <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign g          = g_q;
    assign f          = f_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign period_cnt = period_cnt_q;

    a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(g_q && f_q));

endmodule
